// File: rtl/syscall_sequencer_pkg.sv
// syscall_sequencer_pkg: SYSCALL service codes and operand width shared with the decoder
package syscall_sequencer_pkg;
  localparam int SYS_OP_LENGTH = 32;
  typedef logic [SYS_OP_LENGTH-1:0] sys_op_t;
  localparam sys_op_t SYSCALL_PRINT_INT  = 32'd1;
  localparam sys_op_t SYSCALL_INPUT_INT  = 32'd5;
  localparam sys_op_t SYSCALL_EXIT       = 32'd10;
  localparam sys_op_t SYSCALL_PRINT_CHAR = 32'd11;
endpackage

// File: rtl/syscall_timeout_cnt.sv
// syscall_timeout_cnt: clearable cycle counter that flags expiry at LIMIT-1 and holds there
module syscall_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT) + 1;
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/syscall_sequencer.sv
// syscall_sequencer: multi-cycle SYSCALL console sequencer; SYSCALL_TIMEOUT_EN adds a transfer timeout.
module syscall_sequencer
  import syscall_sequencer_pkg::*;
#(
`ifdef SYSCALL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1024,
`endif
  parameter int DATA_W   = 32,
  parameter int SYS_OP_W = SYS_OP_LENGTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                syscall,
  input  logic [SYS_OP_W-1:0] sys_op,
  input  logic [DATA_W-1:0]   arg,
  output logic                stall,
  output logic                wb_en,
  output logic [DATA_W-1:0]   wb_data,
  output logic                exit,
  output logic                err,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_is_char,
  input  logic                out_ready,
  output logic                in_req,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data
);
  typedef enum logic [2:0] {IDLE, OUT, IN, DONE, HALT} state_t;
  state_t state, nxt;
  logic trig, go_out, go_in, go_halt, bad_op, busy, tmo, rd_svc;
  assign trig    = state == IDLE && syscall;
  assign go_out  = trig && (sys_op == SYSCALL_PRINT_INT || sys_op == SYSCALL_PRINT_CHAR);
  assign go_in   = trig && sys_op == SYSCALL_INPUT_INT;
  assign go_halt = trig && sys_op == SYSCALL_EXIT;
  assign bad_op  = trig && !(go_out || go_in || go_halt);
  assign busy    = state == OUT || state == IN;
  assign stall   = (state == IDLE) ? (go_out || go_in || go_halt) : (state != DONE);
  assign wb_en   = state == DONE && rd_svc;
`ifdef SYSCALL_TIMEOUT_EN
  logic expired;
  syscall_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .rst(rst), .clr(go_out || go_in), .en(busy), .expired(expired)
  );
  assign tmo = busy && expired;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state == IDLE ? (go_out ? OUT : go_in ? IN : go_halt ? HALT : IDLE)
        : state == OUT  ? ((out_valid && out_ready) || tmo ? DONE : OUT)
        : state == IN   ? (in_valid || tmo ? DONE : IN)
        : state == DONE ? IDLE : HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      in_req      <= 1'b0;
      exit        <= 1'b0;
      err         <= 1'b0;
      rd_svc      <= 1'b0;
      out_is_char <= 1'b0;
      out_data    <= '0;
      wb_data     <= '0;
    end else begin
      state     <= nxt;
      out_valid <= nxt == OUT;
      in_req    <= nxt == IN;
      exit      <= nxt == HALT;
      err       <= err || bad_op || tmo;
      if (trig) rd_svc <= go_in;
      if (go_out) begin
        out_data    <= arg;
        out_is_char <= sys_op == SYSCALL_PRINT_CHAR;
      end
      // a real handshake wins over a same-cycle timeout
      if (state == IN && (in_valid || tmo)) wb_data <= in_valid ? in_data : '0;
    end
  end
endmodule

// File: tb/tb_syscall_sequencer.sv
// tb_syscall_sequencer: scoreboard bench for syscall_sequencer; SYSCALL_TIMEOUT_EN also covers the timeout path.
module tb_syscall_sequencer;
  logic clk = 0, rst, syscall, stall, wb_en, exit, err, out_valid, out_is_char, out_ready, in_req, in_valid;
  logic [31:0] sys_op, arg, wb_data, out_data, in_data;
  typedef struct {bit rd; logic [31:0] data; bit ch;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  syscall_sequencer #(
`ifdef SYSCALL_TIMEOUT_EN
    .TIMEOUT_CYCLES(8),
`endif
    .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .sys_op(sys_op), .arg(arg),
    .stall(stall), .wb_en(wb_en), .wb_data(wb_data), .exit(exit), .err(err),
    .out_valid(out_valid), .out_data(out_data), .out_is_char(out_is_char), .out_ready(out_ready),
    .in_req(in_req), .in_valid(in_valid), .in_data(in_data)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("wr_kind", 32'(e.rd), 0);
        check("out_data", out_data, e.data);
        check("out_is_char", 32'(out_is_char), 32'(e.ch));
      end
    end
    if (!rst && wb_en) begin
      if (q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("wb_kind", 32'(e.rd), 1);
        check("wb_data", wb_data, e.data);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] op, input logic [31:0] a, input int rdy_at, input int vld_at,
                     output int st, output logic wbe);
    bit done = 0;
    st = 0;
    wbe = 0;
    syscall = 1;
    sys_op = op;
    arg = a;
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = c >= rdy_at;
      in_valid = c == vld_at;
      @(negedge clk);
      if (stall) st++;
      else begin
        wbe = wb_en;
        done = 1;
      end
      cyc();
    end
    if (!done) check("svc_bound", 0, 1);
    syscall = 0;
    out_ready = 0;
    in_valid = 0;
  endtask
  initial begin
    int st;
    logic wbe;
    bit ok;
    rst = 1; syscall = 0; sys_op = 0; arg = 0; out_ready = 0; in_valid = 0; in_data = 0;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_outs", {out_valid, in_req, exit, err, wb_en}, 0);
    check("rst_data", out_data | wb_data, 0);
    cyc();
    // print-int, console busy for four OUT cycles
    q.push_back('{0, 32'h2A, 0});
    in_data = 32'h1234_5678;
    run(1, 32'h2A, 5, 0, st, wbe);
    check("pint_stall", st, 6);
    check("pint_wben", 32'(wbe), 0);
    // read-int, data on third IN cycle; syscall held through DONE
    q.push_back('{1, 32'hFFFF_FFF9, 0});
    in_data = 32'hFFFF_FFF9;
    run(5, 0, 99, 3, st, wbe);
    check("rint_stall", st, 4);
    check("rint_wben", 32'(wbe), 1);
    @(negedge clk);
    check("rint_noretrig", 32'(stall), 0);
    cyc();
    // print-char, ready already high
    q.push_back('{0, 32'h41, 1});
    run(11, 32'h41, 0, 99, st, wbe);
    check("pchr_stall", st, 2);
    check("pchr_wben", 32'(wbe), 0);
    // reset mid-OUT
    syscall = 1; sys_op = 1; arg = 32'h77;
    cyc(); cyc();
    @(negedge clk);
    check("mid_out_valid", 32'(out_valid), 1);
    cyc();
    syscall = 0; rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    check("post_rst", {out_valid, stall, exit, err}, 0);
    cyc();
    // unknown code retires as NOP with err
    syscall = 1; sys_op = 7;
    @(negedge clk);
    check("bad_stall", 32'(stall), 0);
    cyc();
    syscall = 0;
    @(negedge clk);
    check("bad_err", 32'(err), 1);
    check("bad_state", {stall, out_valid, in_req}, 0);
    cyc();
    // exit is sticky until reset
    syscall = 1; sys_op = 10;
    cyc();
    syscall = 0;
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(exit && stall)) ok = 0;
      cyc();
    end
    check("exit_hold", 32'(ok), 1);
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    check("exit_rst", {exit, stall, err}, 0);
    cyc();
`ifdef SYSCALL_TIMEOUT_EN
    q.push_back('{1, 32'h0, 0});
    in_data = 32'hDEAD_BEEF;
    run(5, 0, 99, 99, st, wbe);
    check("tmo_stall", st, 9);
    check("tmo_wben", 32'(wbe), 1);
    @(negedge clk);
    check("tmo_err", 32'(err), 1);
    check("tmo_wbdata", wb_data, 0);
    cyc();
`endif
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
